dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the execute unit's data-memory interface.
- Accepts MEM_READ and MEM_WRITE requests, services them from an internal word RAM or a small MMIO window, and returns read data with a parameterised latency plus a valid strobe.
- Drives a ready signal so execute can stall on multi-cycle reads.
- Sits beside the instruction memory in the core top level and replaces the data port of the shared memory.

Parameters:
- MEM_WIDTH, 16: word-address bits; the RAM holds 2^MEM_WIDTH 32-bit words.
- READ_LATENCY, 1: cycles from the read-accept edge to valid data. Legal range 1..4.
- MMIO_BASE, 32'hFFFF_FFF0: byte address of the 16-byte MMIO window.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- dmem_control  in  2  MemControlT: 0 = MEM_NONE, 1 = MEM_READ, 2 = MEM_WRITE; 3 is treated as NONE
- dmem_addr  in  32  byte address
- dmem_writedata  in  32  store data
- dmem_ready  out  1  responder can accept a request this cycle
- dmem_readdata  out  32  load data, meaningful only while dmem_readdata_valid=1
- dmem_readdata_valid  out  1  one-cycle strobe per accepted read
- console_valid  out  1  one-cycle pulse on a console write
- console_data  out  8  byte written to the console, held until the next console write
- halt  out  1  sticky; set by a write to the halt register
- misaligned_err  out  1  sticky; set by any access with dmem_addr[1:0] != 0

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs:
  - dmem_ready=1, dmem_readdata=0, dmem_readdata_valid=0, console_valid=0, console_data=0, halt=0, misaligned_err=0.
  - State returns to IDLE; cycle counter = 0.
  - RAM contents are not reset.
- Accept rule: a request is accepted at a rising edge when dmem_ready=1 and dmem_control is READ or WRITE.
  - Requests presented while dmem_ready=0 are ignored; the initiator holds the request.
- State machine: IDLE and WAIT.
  - IDLE: dmem_ready=1.
  - Accepted read with READ_LATENCY>1: move to WAIT, load the wait counter with READ_LATENCY-1, drive dmem_ready=0.
  - WAIT: decrement the counter each edge. On the edge where it reaches 0, register data, assert valid and return to IDLE.
  - Accepted write: always stays in IDLE.
- Read timing: for a read accepted at edge k, dmem_readdata_valid is registered high at edge k+READ_LATENCY-1 and low again at the next edge.
  - READ_LATENCY=1: valid is high during the cycle after the accept edge, and back-to-back reads are accepted every cycle.
  - READ_LATENCY=L>1: dmem_ready is low from edge k to edge k+L-1; the next accept is possible at edge k+L.
- Write timing: the RAM or MMIO write takes effect at the accept edge. No valid strobe is produced.
- RAM addressing:
  - Word index = dmem_addr[MEM_WIDTH+1:2].
  - Upper address bits outside the MMIO window are ignored (aliasing).
  - Read data is the RAM content at the accept edge. A write in the same cycle is impossible because only one request is outstanding.
- MMIO window, addresses MMIO_BASE+0..+15, decoded on dmem_addr[3:2]:
  - +0 console: a write sets console_data=writedata[7:0] and pulses console_valid for one cycle. A read returns 0.
  - +4 halt: a write with writedata[0]=1 sets halt (a write of 0 does not clear it). A read returns {31'b0, halt}.
  - +8 cycle counter: 32-bit, free-running from reset, wraps at 2^32. A read returns the count at the accept edge. Writes are ignored.
  - +12: reads return 0; writes are ignored.
- Misaligned access (addr[1:0] != 0):
  - Sets misaligned_err.
  - A misaligned write is dropped.
  - A misaligned read still follows normal timing, with readdata=0.
- Reset mid-read: a pending WAIT is abandoned and no valid strobe is ever produced for it. After reset deasserts, dmem_ready=1.

Test Plan:
- Reset with rst=0; write RAM word addr 0x40 = 0xDEADBEEF; read 0x40 (READ_LATENCY=1) -> valid=1 in the next cycle with readdata=0xDEADBEEF; dmem_ready stays 1.
- READ_LATENCY=3: read accepted at edge k -> dmem_ready=0 for edges k..k+2, valid high exactly one cycle after edge k+2; a second read held during WAIT is accepted at edge k+3.
- Write 0x00000041 to 0xFFFF_FFF0 -> console_valid pulses for one cycle, console_data=0x41. Write 1 to 0xFFFF_FFF4 -> halt=1; then write 0 -> halt remains 1; read 0xFFFF_FFF4 -> 0x00000001.
- Write 0x12345678 to 0x42 (misaligned) -> misaligned_err=1 and the RAM word at 0x40 is unchanged. A read of 0x43 returns valid with readdata=0.
- Aliasing with MEM_WIDTH=16: write 0xA5A5A5A5 to 0x0004_0000 -> a read of 0x0000_0000 returns 0xA5A5A5A5.
- READ_LATENCY=4: read accepted, then rst=0 two cycles later -> no valid strobe; after release dmem_ready=1, the cycle counter restarts at 0, and a read of 0xFFFF_FFF8 returns a small count consistent with the cycles elapsed.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 16-byte MMIO window (console, halt,
// cycle counter), with a configurable read latency and a ready/valid handshake.
module dmem_responder #(
  parameter int unsigned MEM_WIDTH    = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dmem_control,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_writedata,
  output logic        dmem_ready,
  output logic [31:0] dmem_readdata,
  output logic        dmem_readdata_valid,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        halt,
  output logic        misaligned_err
);

  localparam int unsigned DEPTH     = 1 << MEM_WIDTH;
  localparam logic [1:0]  WAIT_INIT = 2'(READ_LATENCY - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [31:0] cycle_q, cycle_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] hold_q, hold_d;
  logic        cvalid_q, cvalid_d;
  logic [7:0]  cdata_q, cdata_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;

  logic [31:0] ram_q [DEPTH];

  logic                 is_read, is_write, aligned, in_mmio, ram_we;
  logic [MEM_WIDTH-1:0] word_idx;
  logic [31:0]          mmio_rd, load_data;

  always_comb begin
    is_read  = ready_q && (dmem_control == 2'd1);
    is_write = ready_q && (dmem_control == 2'd2);
    aligned  = (dmem_addr[1:0] == 2'b00);
    in_mmio  = (dmem_addr[31:4] == MMIO_BASE[31:4]);
    word_idx = dmem_addr[MEM_WIDTH+1:2];
    ram_we   = is_write && aligned && !in_mmio;

    case (dmem_addr[3:2])
      2'd1:    mmio_rd = {31'b0, halt_q};
      2'd2:    mmio_rd = cycle_q;
      default: mmio_rd = '0;
    endcase

    if (!aligned)     load_data = '0;
    else if (in_mmio) load_data = mmio_rd;
    else              load_data = ram_q[word_idx];
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    cycle_d  = cycle_q + 32'd1;
    ready_d  = ready_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    hold_d   = hold_q;
    cvalid_d = 1'b0;
    cdata_d  = cdata_q;
    halt_d   = halt_q;
    err_d    = err_q | ((is_read | is_write) & ~aligned);

    if (is_write && aligned && in_mmio) begin
      case (dmem_addr[3:2])
        2'd0: begin
          cdata_d  = dmem_writedata[7:0];
          cvalid_d = 1'b1;
        end
        2'd1:    halt_d = halt_q | dmem_writedata[0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (is_read) begin
          if (READ_LATENCY <= 1) begin
            rdata_d  = load_data;
            rvalid_d = 1'b1;
          end else begin
            // Snapshot at accept so the returned value reflects the accept edge.
            hold_d  = load_data;
            wcnt_d  = WAIT_INIT;
            ready_d = 1'b0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 2'd1;
        if (wcnt_q == 2'd1) begin
          rdata_d  = hold_q;
          rvalid_d = 1'b1;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      cycle_q  <= '0;
      ready_q  <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      hold_q   <= '0;
      cvalid_q <= 1'b0;
      cdata_q  <= '0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      cycle_q  <= cycle_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      hold_q   <= hold_d;
      cvalid_q <= cvalid_d;
      cdata_q  <= cdata_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[word_idx] <= dmem_writedata;
  end

  assign dmem_ready          = ready_q;
  assign dmem_readdata       = rdata_q;
  assign dmem_readdata_valid = rvalid_q;
  assign console_valid       = cvalid_q;
  assign console_data        = cdata_q;
  assign halt                = halt_q;
  assign misaligned_err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 1, 3, 4) on a shared request bus,
// directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ctrl = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;

  // index 0: latency 1, index 1: latency 3, index 2: latency 4
  logic        rdy  [3];
  logic [31:0] rdat [3];
  logic        rval [3];
  logic        cval [3];
  logic [7:0]  cdat [3];
  logic        hlt  [3];
  logic        merr [3];

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WIDTH(16), .READ_LATENCY(1), .MMIO_BASE(32'hFFFF_FFF0)) u_l1 (
    .clk(clk), .rst(rst), .dmem_control(ctrl), .dmem_addr(addr), .dmem_writedata(wd),
    .dmem_ready(rdy[0]), .dmem_readdata(rdat[0]), .dmem_readdata_valid(rval[0]),
    .console_valid(cval[0]), .console_data(cdat[0]), .halt(hlt[0]), .misaligned_err(merr[0]));

  dmem_responder #(.MEM_WIDTH(8), .READ_LATENCY(3), .MMIO_BASE(32'hFFFF_FFF0)) u_l3 (
    .clk(clk), .rst(rst), .dmem_control(ctrl), .dmem_addr(addr), .dmem_writedata(wd),
    .dmem_ready(rdy[1]), .dmem_readdata(rdat[1]), .dmem_readdata_valid(rval[1]),
    .console_valid(cval[1]), .console_data(cdat[1]), .halt(hlt[1]), .misaligned_err(merr[1]));

  dmem_responder #(.MEM_WIDTH(8), .READ_LATENCY(4), .MMIO_BASE(32'hFFFF_FFF0)) u_l4 (
    .clk(clk), .rst(rst), .dmem_control(ctrl), .dmem_addr(addr), .dmem_writedata(wd),
    .dmem_ready(rdy[2]), .dmem_readdata(rdat[2]), .dmem_readdata_valid(rval[2]),
    .console_valid(cval[2]), .console_data(cdat[2]), .halt(hlt[2]), .misaligned_err(merr[2]));

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic req(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w);
    ctrl = c; addr = a; wd = w;
  endtask

  task automatic idle_n(input int n);
    ctrl = 2'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    ctrl = 2'd0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    ctrl = 2'd0;
    rst = 1'b0;
    tick();
    if (rdy[0] !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", rdy[0]); end checks++;
    if (rdat[0] !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%08h exp=0", rdat[0]); end checks++;
    if (rval[0] !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rval[0]); end checks++;
    if (cval[0] !== 1'b0) begin failures++; $display("FAIL reset_cvalid got=%0b exp=0", cval[0]); end checks++;
    if (cdat[0] !== 8'h0) begin failures++; $display("FAIL reset_cdata got=%02h exp=0", cdat[0]); end checks++;
    if (hlt[0] !== 1'b0) begin failures++; $display("FAIL reset_halt got=%0b exp=0", hlt[0]); end checks++;
    if (merr[0] !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", merr[0]); end checks++;
    if (rdy[2] !== 1'b1) begin failures++; $display("FAIL reset_ready_l4 got=%0b exp=1", rdy[2]); end checks++;
    tick();
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_basic();
    req(2'd2, 32'h40, 32'hDEADBEEF);
    tick();
    if (rval[0] !== 1'b0) begin failures++; $display("FAIL write_no_valid got=%0b exp=0", rval[0]); end checks++;
    req(2'd1, 32'h40, 32'h0);
    tick();
    if (rval[0] !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", rval[0]); end checks++;
    if (rdat[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rdata got=%08h exp=deadbeef", rdat[0]); end checks++;
    if (rdy[0] !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", rdy[0]); end checks++;
    idle_n(1);
    if (rval[0] !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0b exp=0", rval[0]); end checks++;
    idle_n(4);
  endtask

  task automatic test_latency3();
    req(2'd2, 32'h44, 32'h0BADF00D);
    tick();
    req(2'd1, 32'h40, 32'h0);
    tick();  // edge k
    if (rdy[1] !== 1'b0 || rval[1] !== 1'b0) begin failures++; $display("FAIL l3_k got=rdy%0b/val%0b exp=0/0", rdy[1], rval[1]); end checks++;
    req(2'd1, 32'h44, 32'h0);
    tick();  // k+1, second read held
    if (rdy[1] !== 1'b0 || rval[1] !== 1'b0) begin failures++; $display("FAIL l3_k1 got=rdy%0b/val%0b exp=0/0", rdy[1], rval[1]); end checks++;
    tick();  // k+2
    if (rdy[1] !== 1'b1 || rval[1] !== 1'b1) begin failures++; $display("FAIL l3_k2 got=rdy%0b/val%0b exp=1/1", rdy[1], rval[1]); end checks++;
    if (rdat[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL l3_rdata1 got=%08h exp=deadbeef", rdat[1]); end checks++;
    tick();  // k+3: held read accepted
    ctrl = 2'd0;
    if (rdy[1] !== 1'b0 || rval[1] !== 1'b0) begin failures++; $display("FAIL l3_k3 got=rdy%0b/val%0b exp=0/0", rdy[1], rval[1]); end checks++;
    tick();
    if (rval[1] !== 1'b0) begin failures++; $display("FAIL l3_k4 got=%0b exp=0", rval[1]); end checks++;
    tick();
    if (rval[1] !== 1'b1 || rdat[1] !== 32'h0BADF00D) begin failures++; $display("FAIL l3_rdata2 got=%0b/%08h exp=1/0badf00d", rval[1], rdat[1]); end checks++;
    tick();
    if (rval[1] !== 1'b0 || rdy[1] !== 1'b1) begin failures++; $display("FAIL l3_end got=val%0b/rdy%0b exp=0/1", rval[1], rdy[1]); end checks++;
    idle_n(4);
  endtask

  task automatic test_mmio();
    req(2'd2, 32'hFFFF_FFF0, 32'h41);
    tick();
    if (cval[0] !== 1'b1 || cdat[0] !== 8'h41) begin failures++; $display("FAIL console_write got=%0b/%02h exp=1/41", cval[0], cdat[0]); end checks++;
    idle_n(1);
    if (cval[0] !== 1'b0 || cdat[0] !== 8'h41) begin failures++; $display("FAIL console_hold got=%0b/%02h exp=0/41", cval[0], cdat[0]); end checks++;
    req(2'd2, 32'hFFFF_FFF4, 32'h0);
    tick();
    if (hlt[0] !== 1'b0) begin failures++; $display("FAIL halt_zero got=%0b exp=0", hlt[0]); end checks++;
    req(2'd2, 32'hFFFF_FFF4, 32'h1);
    tick();
    if (hlt[0] !== 1'b1) begin failures++; $display("FAIL halt_set got=%0b exp=1", hlt[0]); end checks++;
    req(2'd2, 32'hFFFF_FFF4, 32'h0);
    tick();
    if (hlt[0] !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%0b exp=1", hlt[0]); end checks++;
    req(2'd1, 32'hFFFF_FFF4, 32'h0);
    tick();
    if (rval[0] !== 1'b1 || rdat[0] !== 32'h1) begin failures++; $display("FAIL halt_read got=%0b/%08h exp=1/00000001", rval[0], rdat[0]); end checks++;
    req(2'd1, 32'hFFFF_FFF0, 32'h0);
    tick();
    if (rval[0] !== 1'b1 || rdat[0] !== 32'h0) begin failures++; $display("FAIL console_read got=%0b/%08h exp=1/0", rval[0], rdat[0]); end checks++;
    req(2'd1, 32'hFFFF_FFFC, 32'h0);
    tick();
    if (rval[0] !== 1'b1 || rdat[0] !== 32'h0) begin failures++; $display("FAIL mmio12_read got=%0b/%08h exp=1/0", rval[0], rdat[0]); end checks++;
    idle_n(4);
  endtask

  task automatic test_misaligned();
    req(2'd2, 32'h42, 32'h12345678);
    tick();
    if (merr[0] !== 1'b1) begin failures++; $display("FAIL misalign_err got=%0b exp=1", merr[0]); end checks++;
    req(2'd1, 32'h40, 32'h0);
    tick();
    if (rdat[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL misalign_dropped got=%08h exp=deadbeef", rdat[0]); end checks++;
    req(2'd1, 32'h43, 32'h0);
    tick();
    if (rval[0] !== 1'b1 || rdat[0] !== 32'h0) begin failures++; $display("FAIL misalign_read got=%0b/%08h exp=1/0", rval[0], rdat[0]); end checks++;
    idle_n(4);
  endtask

  task automatic test_alias();
    req(2'd2, 32'h0004_0000, 32'hA5A5A5A5);
    tick();
    req(2'd1, 32'h0000_0000, 32'h0);
    tick();
    if (rval[0] !== 1'b1 || rdat[0] !== 32'hA5A5A5A5) begin failures++; $display("FAIL alias_read got=%0b/%08h exp=1/a5a5a5a5", rval[0], rdat[0]); end checks++;
    idle_n(4);
  endtask

  // Random traffic on the latency-1 instance against a plain behavioural model.
  task automatic test_random();
    logic [31:0] model_mem [int unsigned];
    int unsigned keys [$];
    logic        m_halt, m_err, exp_cval;
    logic [7:0]  m_cdat;
    logic        exp_val;
    logic [31:0] exp_dat, a, w;
    int unsigned k, op;
    do_reset();
    m_halt = 1'b0; m_err = 1'b0; m_cdat = 8'h0;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      exp_val = 1'b0; exp_dat = '0; exp_cval = 1'b0;
      w = $urandom;
      if (op <= 3 || (op <= 6 && keys.size() == 0)) begin
        a = $urandom & 32'hFFFF_FFFC;
        if (a[31:4] == 28'hFFFF_FFF) a = 32'h100;
        k = int'(a[17:2]);
        if (!model_mem.exists(k)) keys.push_back(k);
        model_mem[k] = w;
        req(2'd2, a, w);
      end else if (op <= 6) begin
        k = keys[$urandom_range(0, keys.size() - 1)];
        a = (k << 2) | ($urandom_range(0, 4095) << 18);
        exp_val = 1'b1; exp_dat = model_mem[k];
        req(2'd1, a, w);
      end else if (op == 7) begin
        a = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
        if ($urandom_range(0, 1) == 1) begin
          if (a == 32'hFFFF_FFF0) begin m_cdat = w[7:0]; exp_cval = 1'b1; end
          if (a == 32'hFFFF_FFF4 && w[0]) m_halt = 1'b1;
          req(2'd2, a, w);
        end else begin
          exp_val = 1'b1;
          if (a == 32'hFFFF_FFF4) exp_dat = {31'b0, m_halt};
          else if (a == 32'hFFFF_FFF8) exp_dat = cyc;
          req(2'd1, a, w);
        end
      end else if (op == 8) begin
        a = ($urandom & 32'hFFFF_FFFC) | $urandom_range(1, 3);
        m_err = 1'b1;
        if ($urandom_range(0, 1) == 1) req(2'd2, a, w);
        else begin exp_val = 1'b1; req(2'd1, a, w); end
      end else begin
        req(($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, $urandom, w);
      end
      tick();
      if (rval[0] !== exp_val) begin failures++; $display("FAIL rnd_valid it=%0d got=%0b exp=%0b", i, rval[0], exp_val); end checks++;
      if (exp_val && rdat[0] !== exp_dat) begin failures++; $display("FAIL rnd_rdata it=%0d addr=%08h got=%08h exp=%08h", i, a, rdat[0], exp_dat); end checks++;
      if (rdy[0] !== 1'b1) begin failures++; $display("FAIL rnd_ready it=%0d got=%0b exp=1", i, rdy[0]); end checks++;
      if (cval[0] !== exp_cval || cdat[0] !== m_cdat) begin failures++; $display("FAIL rnd_console it=%0d got=%0b/%02h exp=%0b/%02h", i, cval[0], cdat[0], exp_cval, m_cdat); end checks++;
      if (hlt[0] !== m_halt || merr[0] !== m_err) begin failures++; $display("FAIL rnd_flags it=%0d got=h%0b/e%0b exp=h%0b/e%0b", i, hlt[0], merr[0], m_halt, m_err); end checks++;
    end
    idle_n(4);
  endtask

  task automatic test_reset_midread();
    do_reset();
    req(2'd1, 32'h40, 32'h0);
    tick();  // accept on latency-4 instance
    ctrl = 2'd0;
    if (rdy[2] !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", rdy[2]); end checks++;
    tick();
    tick();
    rst = 1'b0;
    #1;
    if (rdy[2] !== 1'b1 || rval[2] !== 1'b0) begin failures++; $display("FAIL mid_reset got=rdy%0b/val%0b exp=1/0", rdy[2], rval[2]); end checks++;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rval[2] !== 1'b0) begin failures++; $display("FAIL mid_in_reset got=%0b exp=0", rval[2]); end checks++;
    end
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rval[2] !== 1'b0 || rdy[2] !== 1'b1) begin failures++; $display("FAIL mid_after got=val%0b/rdy%0b exp=0/1", rval[2], rdy[2]); end checks++;
    end
    req(2'd1, 32'hFFFF_FFF8, 32'h0);
    tick();
    ctrl = 2'd0;
    tick();
    tick();
    if (rval[2] !== 1'b0) begin failures++; $display("FAIL mid_cnt_early got=%0b exp=0", rval[2]); end checks++;
    tick();
    if (rval[2] !== 1'b1 || rdat[2] !== 32'd4) begin failures++; $display("FAIL mid_cnt_read got=%0b/%0d exp=1/4", rval[2], rdat[2]); end checks++;
    idle_n(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency3();
    test_mmio();
    test_misaligned();
    test_alias();
    test_random();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
